datapath_pipe: RTL
==================

# datapath_pipe

Parametrised two-stage pipelined datapath: an NREG x W register file, a function unit and a registered V/C/N/Z status word, all driven by one control word per cycle. It is the successor to the single-cycle 16-bit/8-register datapath. New relative to that design: width and depth are parameters, operand-fetch and execute/write-back are separate pipeline stages, EX->OF forwarding makes back-to-back dependent control words correct, and a HOLD input freezes the pipeline. The control unit drives it; Adrout and Dout feed the memory interface.

## Interface
- W, 16, datapath and register width (>= 4)
- NREG, 8, number of registers (power of two, >= 2)
- AW, $clog2(NREG), register address width (derived; not overridden)
- CW, 3*AW+7, control word width (16 at defaults)
- CLK  input  1  clock; all state updates on rising edge
- RESET  input  1  synchronous, active-high reset
- CTRWRD  input  CW  control word, MSB->LSB: DA[AW], AA[AW], BA[AW], MB, FS[4], MD, RW
- Cin  input  W  constant operand, used as B when MB=1
- Din  input  W  memory data, written to R[DA] when MD=1
- HOLD  input  1  freeze pipeline; CTRWRD/Cin/Din ignored while high
- Adrout  output  W  A operand of the instruction in EX (address bus)
- Dout  output  W  B operand (after MB mux) of the instruction in EX (data bus)
- V, C, N, Z  output  1 each  registered overflow, carry, negative, zero flags

## Operation
- OF stage (combinational read, registered at edge): A = R[AA], B = MB ? Cin : R[BA]. Forwarding applies to each operand independently when: EX valid, EX RW=1, EX DA == AA (or BA when MB=0). The operand then takes the EX write value D, not the register file.
- OF->EX register captures A, B, DA, FS, MD, RW, Din and a valid bit. The valid bit is 1 on every non-HOLD cycle after reset.
- EX stage: F = FU(A, B, FS). D = MD ? Din_captured : F. At the edge ending EX, if valid and RW, R[DA] <= D.
- FS codes:
  - 0000 A; 0001 A+1; 0010 A+B; 0011 A+B+1; 0100 A+~B; 0101 A+~B+1; 0110 A-1 (A+all-ones); 0111 A
  - 1000 A&B; 1001 A|B; 1010 A^B; 1011 ~A; 1100 B
  - 1101 B>>1 (logical); 1110 B<<1
  - 1111 all-zeros
- Arithmetic uses a (W+1)-bit sum. C = bit W of that sum. V = signed overflow of the add performed (operand signs equal, result sign differs).
- Codes 1000-1100 and 1111: C=0, V=0.
- Shifts: C = the bit shifted out; V=0.
- N = F[W-1]; Z = (F == 0).
- Flags update at the EX edge only when valid and MD=0, whether or not RW is set. Otherwise flags hold.
- All registers, including R0, are writable.

## Timing
- Reset values: all registers, pipeline registers and valid = 0. Adrout = Dout = 0, V=C=N=Z=0.
- RESET has priority over HOLD and over any pending write. A write in EX during the RESET cycle is discarded.
- Latency: a control word applied before edge n is in EX during cycle n. R[DA] and the flags update at edge n+1. A dependent control word applied in cycle n sees the value through forwarding, with zero bubbles.
- Adrout/Dout are valid during the EX cycle and change only at edges.
- HOLD=1 at edge n:
  - the OF->EX register keeps its contents;
  - no register file write, no flag update;
  - Adrout/Dout stay stable.
  On release, the held instruction writes exactly once at the next edge.
- Write and forward the same register in the same cycle: the forwarded D wins; the register file is never read stale.
- DA outside 0..NREG-1 cannot occur (AW exact).

## Structure
- Package datapath_pkg: FS code localparams; CTRWRD field offset/width functions of AW; flag index constants.
- Sub-module dp_function_unit (combinational, parameter W): inputs A, B, FS; outputs F, V, C, N, Z.
- The register file, forwarding muxes and pipeline register stay in datapath_pipe.

## Test plan
- Reset, then 8 cycles loading Ri <= i (DA=i, MD=1, RW=1, Din=i). One cycle later, read each via AA=i, FS=0000: Adrout = i. After reset, all outputs are 0.
- RAW chain: R1=1, R2=2. Then R3=R1+R2 (FS 0010) immediately followed by R4=R3+R3. Required: R4 = 6, Adrout = 3 in the second EX cycle, Z=0, N=0, no bubble.
- MB constant: Cin=2, R1 = R1+Cin (MB=1, FS 0010) with R1=1. Required: R1 = 3, Dout = 2 during EX.
- Flag corners:
  - R2-R2 (FS 0101) -> 0, Z=1, C=1, N=0, V=0.
  - R6=0x7FFF then R7=R6+1 (FS 0001) -> 0x8000, V=1, N=1, C=0, Z=0.
  - MD=1 load does not change flags.
- HOLD 3 cycles with R5 <= R1+R2 in EX: R5 unchanged, flags unchanged, Adrout/Dout stable. On release, R5 = 3 written once; a following dependent word forwards 3.
- RESET asserted while RW=1 word is in EX (Din=0xEFFF, MD=1): the write is suppressed, all registers read 0, flags 0, valid 0 on the next cycle.

Source files
------------

// File: rtl/datapath_pkg.sv
// datapath_pkg
//   Shared definitions for the pipelined datapath:
//   - function-select (FS) codes of the function unit
//   - control-word field positions, expressed as functions of the register
//     address width AW (word layout MSB->LSB: DA, AA, BA, MB, FS[4], MD, RW)
//   - bit positions of V/C/N/Z inside the packed status word
package datapath_pkg;

  localparam int FS_W = 4;

  localparam logic [3:0] FS_PASSA  = 4'b0000;
  localparam logic [3:0] FS_INC    = 4'b0001;
  localparam logic [3:0] FS_ADD    = 4'b0010;
  localparam logic [3:0] FS_ADDC   = 4'b0011;
  localparam logic [3:0] FS_ADDNB  = 4'b0100;
  localparam logic [3:0] FS_SUB    = 4'b0101;
  localparam logic [3:0] FS_DEC    = 4'b0110;
  localparam logic [3:0] FS_PASSA2 = 4'b0111;
  localparam logic [3:0] FS_AND    = 4'b1000;
  localparam logic [3:0] FS_OR     = 4'b1001;
  localparam logic [3:0] FS_XOR    = 4'b1010;
  localparam logic [3:0] FS_NOTA   = 4'b1011;
  localparam logic [3:0] FS_PASSB  = 4'b1100;
  localparam logic [3:0] FS_SHR    = 4'b1101;
  localparam logic [3:0] FS_SHL    = 4'b1110;
  localparam logic [3:0] FS_ZERO   = 4'b1111;

  // Fixed low-order control-word fields
  localparam int CW_RW_BIT = 0;
  localparam int CW_MD_BIT = 1;
  localparam int CW_FS_LSB = 2;
  localparam int CW_MB_BIT = 6;

  // Status-word bit positions
  localparam int FLAG_Z = 0;
  localparam int FLAG_N = 1;
  localparam int FLAG_C = 2;
  localparam int FLAG_V = 3;

  function automatic int cw_width(input int aw);
    return 3 * aw + 7;
  endfunction

  function automatic int ba_lsb(input int aw);
    return 7 + 0 * aw;
  endfunction

  function automatic int aa_lsb(input int aw);
    return 7 + aw;
  endfunction

  function automatic int da_lsb(input int aw);
    return 7 + 2 * aw;
  endfunction

  // Place the four flags at their status-word positions
  function automatic logic [3:0] pack_flags(input logic v, input logic c,
                                            input logic n, input logic z);
    logic [3:0] f;
    f         = 4'b0000;
    f[FLAG_V] = v;
    f[FLAG_C] = c;
    f[FLAG_N] = n;
    f[FLAG_Z] = z;
    return f;
  endfunction

endpackage

// File: rtl/dp_function_unit.sv
// dp_function_unit
//   Purely combinational function unit of the datapath.
//   Ports:
//     i_a, i_b  W-bit operands
//     i_fs      4-bit function select (codes in datapath_pkg)
//     o_f       W-bit result
//     o_v/o_c   overflow / carry of the selected operation
//     o_n/o_z   sign bit of o_f / o_f is all zeros
module dp_function_unit
  import datapath_pkg::*;
#(
  parameter int W = 16
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  logic [3:0]   i_fs,
  output logic [W-1:0] o_f,
  output logic         o_v,
  output logic         o_c,
  output logic         o_n,
  output logic         o_z
);

  logic [W-1:0] w_y;
  logic         w_cin;
  logic [W:0]   w_sum;
  logic [W-1:0] w_f;
  logic         w_v;
  logic         w_c;

  // Second adder operand and carry-in; every arithmetic code is A + y + cin
  always_comb begin
    w_y   = {W{1'b0}};
    w_cin = 1'b0;
    case (i_fs)
      FS_INC:   begin w_y = {W{1'b0}}; w_cin = 1'b1; end
      FS_ADD:   begin w_y = i_b;       w_cin = 1'b0; end
      FS_ADDC:  begin w_y = i_b;       w_cin = 1'b1; end
      FS_ADDNB: begin w_y = ~i_b;      w_cin = 1'b0; end
      FS_SUB:   begin w_y = ~i_b;      w_cin = 1'b1; end
      FS_DEC:   begin w_y = {W{1'b1}}; w_cin = 1'b0; end
      default:  begin w_y = {W{1'b0}}; w_cin = 1'b0; end
    endcase
  end

  assign w_sum = {1'b0, i_a} + {1'b0, w_y} + {{W{1'b0}}, w_cin};

  // Result and carry/overflow selection
  always_comb begin
    w_f = {W{1'b0}};
    w_c = 1'b0;
    w_v = 1'b0;
    case (i_fs)
      FS_PASSA, FS_INC, FS_ADD, FS_ADDC, FS_ADDNB, FS_SUB, FS_DEC, FS_PASSA2: begin
        w_f = w_sum[W-1:0];
        w_c = w_sum[W];
        // Overflow: adder inputs agree in sign, result does not
        w_v = (i_a[W-1] == w_y[W-1]) && (w_sum[W-1] != i_a[W-1]);
      end
      FS_AND:   w_f = i_a & i_b;
      FS_OR:    w_f = i_a | i_b;
      FS_XOR:   w_f = i_a ^ i_b;
      FS_NOTA:  w_f = ~i_a;
      FS_PASSB: w_f = i_b;
      FS_SHR: begin
        w_f = {1'b0, i_b[W-1:1]};
        w_c = i_b[0];
      end
      FS_SHL: begin
        w_f = {i_b[W-2:0], 1'b0};
        w_c = i_b[W-1];
      end
      FS_ZERO:  w_f = {W{1'b0}};
      default:  w_f = {W{1'b0}};
    endcase
  end

  assign o_f = w_f;
  assign o_c = w_c;
  assign o_v = w_v;
  assign o_n = w_f[W-1];
  assign o_z = (w_f == {W{1'b0}});

endmodule

// File: rtl/datapath_pipe.sv
// datapath_pipe
//   Two-stage pipelined datapath: operand fetch (OF) then execute/write-back
//   (EX). NREG x W register file, function unit, registered V/C/N/Z.
//   Ports:
//     CLK, RESET      clock, synchronous active-high reset
//     CTRWRD          control word {DA, AA, BA, MB, FS[4], MD, RW}
//     Cin             constant operand (B when MB=1)
//     Din             memory data (write-back source when MD=1)
//     HOLD            freezes the pipeline, inputs ignored
//     Adrout, Dout    A and B operands of the instruction in EX
//     V, C, N, Z      registered status flags
module datapath_pipe
  import datapath_pkg::*;
#(
  parameter  int W    = 16,
  parameter  int NREG = 8,
  localparam int AW   = $clog2(NREG),
  localparam int CW   = 3 * AW + 7
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic [CW-1:0] CTRWRD,
  input  logic [W-1:0]  Cin,
  input  logic [W-1:0]  Din,
  input  logic          HOLD,
  output logic [W-1:0]  Adrout,
  output logic [W-1:0]  Dout,
  output logic          V,
  output logic          C,
  output logic          N,
  output logic          Z
);

  localparam int DA_LSB = da_lsb(AW);
  localparam int AA_LSB = aa_lsb(AW);
  localparam int BA_LSB = ba_lsb(AW);

  // Control-word fields of the instruction in OF
  logic [AW-1:0] w_da;
  logic [AW-1:0] w_aa;
  logic [AW-1:0] w_ba;
  logic          w_mb;
  logic [3:0]    w_fs;
  logic          w_md;
  logic          w_rw;

  assign w_da = CTRWRD[DA_LSB +: AW];
  assign w_aa = CTRWRD[AA_LSB +: AW];
  assign w_ba = CTRWRD[BA_LSB +: AW];
  assign w_mb = CTRWRD[CW_MB_BIT];
  assign w_fs = CTRWRD[CW_FS_LSB +: FS_W];
  assign w_md = CTRWRD[CW_MD_BIT];
  assign w_rw = CTRWRD[CW_RW_BIT];

  // Architectural state
  logic [W-1:0]  r_regs [NREG];
  logic [3:0]    r_flags;

  // OF->EX pipeline register
  logic [W-1:0]  r_ex_a;
  logic [W-1:0]  r_ex_b;
  logic [AW-1:0] r_ex_da;
  logic [3:0]    r_ex_fs;
  logic          r_ex_md;
  logic          r_ex_rw;
  logic [W-1:0]  r_ex_din;
  logic          r_ex_valid;

  // EX stage results
  logic [W-1:0]  w_f;
  logic          w_fv;
  logic          w_fc;
  logic          w_fn;
  logic          w_fz;
  logic [W-1:0]  w_ex_d;
  logic          w_ex_wr;

  dp_function_unit #(.W(W)) u_fu (
    .i_a  (r_ex_a),
    .i_b  (r_ex_b),
    .i_fs (r_ex_fs),
    .o_f  (w_f),
    .o_v  (w_fv),
    .o_c  (w_fc),
    .o_n  (w_fn),
    .o_z  (w_fz)
  );

  assign w_ex_d  = r_ex_md ? r_ex_din : w_f;
  assign w_ex_wr = r_ex_valid && r_ex_rw;

  // OF operands; a pending EX write to the same register overrides the
  // register file so a dependent word needs no bubble
  logic [W-1:0] w_of_a;
  logic [W-1:0] w_of_b;

  // Operand A fetch with EX->OF bypass
  always_comb begin
    if (w_ex_wr && (r_ex_da == w_aa)) begin
      w_of_a = w_ex_d;
    end else begin
      w_of_a = r_regs[w_aa];
    end
  end

  // Operand B fetch: constant when MB=1, otherwise register with bypass
  always_comb begin
    if (w_mb) begin
      w_of_b = Cin;
    end else if (w_ex_wr && (r_ex_da == w_ba)) begin
      w_of_b = w_ex_d;
    end else begin
      w_of_b = r_regs[w_ba];
    end
  end

  // Pipeline advance: write-back, flag update and OF->EX capture; HOLD
  // freezes everything, RESET overrides both HOLD and a pending write
  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int i = 0; i < NREG; i++) begin
        r_regs[i] <= {W{1'b0}};
      end
      r_flags    <= 4'b0000;
      r_ex_a     <= {W{1'b0}};
      r_ex_b     <= {W{1'b0}};
      r_ex_da    <= {AW{1'b0}};
      r_ex_fs    <= 4'b0000;
      r_ex_md    <= 1'b0;
      r_ex_rw    <= 1'b0;
      r_ex_din   <= {W{1'b0}};
      r_ex_valid <= 1'b0;
    end else if (!HOLD) begin
      if (w_ex_wr) begin
        r_regs[r_ex_da] <= w_ex_d;
      end
      // Memory loads (MD=1) leave the flags alone
      if (r_ex_valid && !r_ex_md) begin
        r_flags <= pack_flags(w_fv, w_fc, w_fn, w_fz);
      end
      r_ex_a     <= w_of_a;
      r_ex_b     <= w_of_b;
      r_ex_da    <= w_da;
      r_ex_fs    <= w_fs;
      r_ex_md    <= w_md;
      r_ex_rw    <= w_rw;
      r_ex_din   <= Din;
      r_ex_valid <= 1'b1;
    end
  end

  assign Adrout = r_ex_a;
  assign Dout   = r_ex_b;
  assign V      = r_flags[FLAG_V];
  assign C      = r_flags[FLAG_C];
  assign N      = r_flags[FLAG_N];
  assign Z      = r_flags[FLAG_Z];

endmodule
